// File: rtl/transposed_buffer_ctrl_pkg.sv
// Shared constants and state encoding for the transposed buffer controller.
package transposed_buffer_ctrl_pkg;
  localparam int SAMPLE_W  = 11;
  localparam int ROWS      = 9;
  localparam int COLS      = 4;
  localparam int COL_W     = SAMPLE_W * ROWS;
  localparam int ROW_CNT_W = $clog2(ROWS);
  localparam int COL_CNT_W = $clog2(COLS);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/transposed_buffer_ctrl_column_mux.sv
// Four-way column selector for the transposed buffer readout.
module column_mux_4to1
  import transposed_buffer_ctrl_pkg::*;
(
  input  logic [COL_W-1:0] col_0,
  input  logic [COL_W-1:0] col_1,
  input  logic [COL_W-1:0] col_2,
  input  logic [COL_W-1:0] col_3,
  input  logic [1:0]       sel,
  output logic [COL_W-1:0] col
);
  always_comb begin
    col = '0;
    unique case (sel)
      2'd0: col = col_0;
      2'd1: col = col_1;
      2'd2: col = col_2;
      2'd3: col = col_3;
      default: col = '0;
    endcase
  end
endmodule

// File: rtl/transposed_buffer_ctrl.sv
// Fill/drain controller for the 9x4 transposed buffer of the interpolation datapath.
// Optional 16-bit BLOCK_CNT output is enabled by TRANSPOSED_BUFFER_CTRL_BLOCK_CNT_EN.
//   state | meaning
//   FILL  | accepting rows, buffer shifts on each accepted row
//   DRAIN | buffer frozen, one column handed downstream per handshake
module transposed_buffer_ctrl
  import transposed_buffer_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_SYNC_N,
  input  logic             FLUSH,
  input  logic             ROW_VALID,
  output logic             ROW_READY,
  output logic             BUF_WRITE_EN,
  input  logic [COL_W-1:0] COL_IN_0,
  input  logic [COL_W-1:0] COL_IN_1,
  input  logic [COL_W-1:0] COL_IN_2,
  input  logic [COL_W-1:0] COL_IN_3,
  output logic             COL_VALID,
  input  logic             COL_READY,
  output logic [COL_W-1:0] COL_OUT,
  output logic [1:0]       COL_IDX,
`ifdef TRANSPOSED_BUFFER_CTRL_BLOCK_CNT_EN
  output logic [15:0]      BLOCK_CNT,
`endif
  output logic             COL_LAST
);
  state_t                 state, state_next;
  logic [ROW_CNT_W-1:0]   row_cnt, row_cnt_next;
  logic [COL_CNT_W-1:0]   col_cnt, col_cnt_next;
  logic [COL_W-1:0]       col_sel;
  logic                   row_acc, col_acc;

  always_ff @(posedge CLK) begin
    if (!RST_SYNC_N) begin
      state   <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      state   <= state_next;
      row_cnt <= row_cnt_next;
      col_cnt <= col_cnt_next;
    end
  end

  assign ROW_READY    = (state == FILL);
  assign COL_VALID    = (state == DRAIN);
  assign row_acc      = ROW_VALID & ROW_READY;
  assign col_acc      = COL_VALID & COL_READY;
  assign BUF_WRITE_EN = row_acc;

  always_comb begin
    state_next   = state;
    row_cnt_next = row_cnt;
    col_cnt_next = col_cnt;
    // An aborted block restarts from an empty count; the buffer itself is simply overwritten.
    if (FLUSH) begin
      state_next   = FILL;
      row_cnt_next = '0;
      col_cnt_next = '0;
    end else begin
      unique case (state)
        FILL: begin
          if (row_acc) begin
            if (row_cnt == ROW_CNT_W'(ROWS - 1)) begin
              state_next   = DRAIN;
              row_cnt_next = '0;
              col_cnt_next = '0;
            end else begin
              row_cnt_next = row_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (col_acc) begin
            if (col_cnt == COL_CNT_W'(COLS - 1)) begin
              state_next   = FILL;
              col_cnt_next = '0;
            end else begin
              col_cnt_next = col_cnt + 1'b1;
            end
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  column_mux_4to1 u_column_mux (
    .col_0 (COL_IN_0),
    .col_1 (COL_IN_1),
    .col_2 (COL_IN_2),
    .col_3 (COL_IN_3),
    .sel   (col_cnt),
    .col   (col_sel)
  );

  assign COL_OUT  = (state == DRAIN) ? col_sel : '0;
  assign COL_IDX  = (state == DRAIN) ? col_cnt : '0;
  assign COL_LAST = (state == DRAIN) && (col_cnt == COL_CNT_W'(COLS - 1));

`ifdef TRANSPOSED_BUFFER_CTRL_BLOCK_CNT_EN
  // Counts completed handshakes of the last column; FLUSH does not clear it.
  always_ff @(posedge CLK) begin
    if (!RST_SYNC_N)
      BLOCK_CNT <= '0;
    else if (col_acc && COL_LAST)
      BLOCK_CNT <= BLOCK_CNT + 16'd1;
  end
`endif
endmodule

// File: tb/tb_transposed_buffer_ctrl.sv
// Self-checking bench for transposed_buffer_ctrl: vector table, directed corner cases, random run vs model.
module tb_transposed_buffer_ctrl;
  import transposed_buffer_ctrl_pkg::*;

  logic             CLK = 1'b0;
  logic             RST_SYNC_N = 1'b0;
  logic             FLUSH = 1'b0;
  logic             ROW_VALID = 1'b0;
  logic             COL_READY = 1'b0;
  logic             ROW_READY, BUF_WRITE_EN, COL_VALID, COL_LAST;
  logic [COL_W-1:0] COL_OUT;
  logic [1:0]       COL_IDX;
  logic [COL_W-1:0] col_in [COLS];
`ifdef TRANSPOSED_BUFFER_CTRL_BLOCK_CNT_EN
  logic [15:0]      BLOCK_CNT;
`endif

  always #5 CLK = ~CLK;

  transposed_buffer_ctrl dut (
    .CLK          (CLK),
    .RST_SYNC_N   (RST_SYNC_N),
    .FLUSH        (FLUSH),
    .ROW_VALID    (ROW_VALID),
    .ROW_READY    (ROW_READY),
    .BUF_WRITE_EN (BUF_WRITE_EN),
    .COL_IN_0     (col_in[0]),
    .COL_IN_1     (col_in[1]),
    .COL_IN_2     (col_in[2]),
    .COL_IN_3     (col_in[3]),
    .COL_VALID    (COL_VALID),
    .COL_READY    (COL_READY),
    .COL_OUT      (COL_OUT),
    .COL_IDX      (COL_IDX),
`ifdef TRANSPOSED_BUFFER_CTRL_BLOCK_CNT_EN
    .BLOCK_CNT    (BLOCK_CNT),
`endif
    .COL_LAST     (COL_LAST)
  );

  // Behavioural buffer: row 0 is the oldest row and lands in the column MSBs.
  logic [SAMPLE_W-1:0] bufm [ROWS][COLS];
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      col_in[c] = '0;
      for (int r = 0; r < ROWS; r++)
        col_in[c][(ROWS-1-r)*SAMPLE_W +: SAMPLE_W] = bufm[r][c];
    end
  end

  int checks = 0;
  int errors = 0;
  int m_rows, m_cols, m_blk, row_seq;
  bit m_ok = 0;
  bit rand_rows = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [COL_W-1:0] exp_col(input int c);
    logic [COL_W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      v[(ROWS-1-r)*SAMPLE_W +: SAMPLE_W] = bufm[r][c];
    return v;
  endfunction

  task automatic compare_model();
    bit dr;
    if (!m_ok) return;
    dr = (m_rows == ROWS);
    check("row_ready", 128'(ROW_READY), 128'(!dr));
    check("col_valid", 128'(COL_VALID), 128'(dr));
    check("col_idx", 128'(COL_IDX), 128'(dr ? m_cols : 0));
    check("col_last", 128'(COL_LAST), 128'(dr && m_cols == COLS - 1));
    check("buf_write_en", 128'(BUF_WRITE_EN), 128'(ROW_VALID && !dr));
    check("col_out", 128'(COL_OUT), 128'(dr ? exp_col(m_cols) : '0));
`ifdef TRANSPOSED_BUFFER_CTRL_BLOCK_CNT_EN
    check("block_cnt", 128'(BLOCK_CNT), 128'(m_blk));
`endif
  endtask

  task automatic drive(input logic rst, input logic fl, input logic rv, input logic cr);
    @(negedge CLK);
    RST_SYNC_N = rst;
    FLUSH      = fl;
    ROW_VALID  = rv;
    COL_READY  = cr;
    #1;
    compare_model();
  endtask

  task automatic tick();
    bit dr;
    dr = 0;
    @(posedge CLK);
    if (m_ok) begin
      dr = (m_rows == ROWS);
      if (ROW_VALID && !dr) begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int c = 0; c < COLS; c++)
            bufm[r][c] = bufm[r+1][c];
        for (int c = 0; c < COLS; c++)
          bufm[ROWS-1][c] = rand_rows ? SAMPLE_W'($urandom) : SAMPLE_W'(row_seq + 16*c);
        row_seq++;
      end
    end
    if (!RST_SYNC_N) begin
      m_rows = 0; m_cols = 0; m_blk = 0; m_ok = 1;
    end else if (m_ok) begin
      if (dr && COL_READY && m_cols == COLS - 1) m_blk = (m_blk + 1) % 65536;
      if (FLUSH) begin
        m_rows = 0; m_cols = 0;
      end else if (!dr) begin
        if (ROW_VALID) m_rows++;
      end else if (COL_READY) begin
        if (m_cols == COLS - 1) begin m_rows = 0; m_cols = 0; end
        else m_cols++;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic rv, input logic cr);
    drive(rst, fl, rv, cr);
    tick();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    row_seq = 0;
  endtask

  typedef struct {
    logic rv, cr;
    logic rr, cv;
    logic [1:0] idx;
    logic last, wen;
  } vec_t;
  vec_t tbl [15];

  logic [COL_W-1:0] held;
  int wen_cnt;

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        bufm[r][c] = '0;

    tbl[0] = '{rv:1'b0, cr:1'b1, rr:1'b1, cv:1'b0, idx:2'd0, last:1'b0, wen:1'b0};
    for (int i = 1; i <= 9; i++)
      tbl[i] = '{rv:1'b1, cr:1'b1, rr:1'b1, cv:1'b0, idx:2'd0, last:1'b0, wen:1'b1};
    for (int i = 10; i <= 13; i++)
      tbl[i] = '{rv:1'b1, cr:1'b1, rr:1'b0, cv:1'b1, idx:2'(i - 10), last:(i == 13), wen:1'b0};
    tbl[14] = '{rv:1'b0, cr:1'b1, rr:1'b1, cv:1'b0, idx:2'd0, last:1'b0, wen:1'b0};

    // Back-to-back block, row k = {k, k+16, k+32, k+48}.
    do_reset();
    check("reset_col_out", 128'(COL_OUT), 128'(0));
    wen_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, tbl[i].rv, tbl[i].cr);
      check("tbl_row_ready", 128'(ROW_READY), 128'(tbl[i].rr));
      check("tbl_col_valid", 128'(COL_VALID), 128'(tbl[i].cv));
      check("tbl_col_idx", 128'(COL_IDX), 128'(tbl[i].idx));
      check("tbl_col_last", 128'(COL_LAST), 128'(tbl[i].last));
      check("tbl_wen", 128'(BUF_WRITE_EN), 128'(tbl[i].wen));
      if (tbl[i].cv) begin
        check("tbl_top_sample", 128'(COL_OUT[COL_W-1 -: SAMPLE_W]), 128'(16 * int'(tbl[i].idx)));
        check("tbl_bot_sample", 128'(COL_OUT[SAMPLE_W-1:0]), 128'(16 * int'(tbl[i].idx) + 8));
      end
      if (BUF_WRITE_EN) wen_cnt++;
      tick();
    end
    check("wen_cycles", 128'(wen_cnt), 128'(9));

    // Backpressure at column 1.
    do_reset();
    for (int i = 0; i < ROWS; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    held = exp_col(1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      check("bp_idx", 128'(COL_IDX), 128'(1));
      check("bp_col_out", 128'(COL_OUT), 128'(held));
      check("bp_row_ready", 128'(ROW_READY), 128'(0));
      tick();
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_resume_idx", 128'(COL_IDX), 128'(2));
    tick();

    // Bubbly upstream: accepted rows on even cycles only.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, (i % 2) == 0, 1'b0);
      check("bubble_no_valid", 128'(COL_VALID), 128'(0));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("bubble_valid", 128'(COL_VALID), 128'(1));
    tick();

    // FLUSH after 5 rows, then FLUSH mid-drain at column 2.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < ROWS; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      check("flush_refill", 128'(COL_VALID), 128'(0));
      tick();
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("flush_at_idx", 128'(COL_IDX), 128'(2));
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("flush_col_valid", 128'(COL_VALID), 128'(0));
    check("flush_row_ready", 128'(ROW_READY), 128'(1));
    tick();

    // Synchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < ROWS; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_pre_valid", 128'(COL_VALID), 128'(1));
    check("rst_pre_idx", 128'(COL_IDX), 128'(1));
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_row_ready", 128'(ROW_READY), 128'(1));
    check("rst_col_valid", 128'(COL_VALID), 128'(0));
    check("rst_col_idx", 128'(COL_IDX), 128'(0));
    check("rst_col_out", 128'(COL_OUT), 128'(0));
    tick();

`ifdef TRANSPOSED_BUFFER_CTRL_BLOCK_CNT_EN
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < ROWS; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < COLS; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("block_cnt_3", 128'(BLOCK_CNT), 128'(3));
    tick();
`endif

    // Random traffic against the model.
    rand_rows = 1;
    do_reset();
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
